// File: rtl/si5340_i2c_responder_if.sv
// ---------------------------------------------------------------------------
// si5340_i2c_responder_if
// Bundles the I2C pin pair, the write-record strobe, the register read port
// and the status flags of the Si5340 I2C responder.
//   scl_i, sda_i  : bus line levels seen by the responder (asynchronous)
//   sda_oe_o      : 1 = responder pulls SDA low, 0 = released
//   wr_valid_o    : one-cycle strobe per received data byte
//   wr_word_o     : {page, reg, data} record for the strobed write
//   rd_addr_o     : {page, reg} of the byte to be transmitted next
//   rd_data_i     : read data for rd_addr_o (valid within 2 clk of a change)
//   busy_o        : high from START to STOP
//   nack_o        : one-cycle strobe on a non-matching address
// The slave modport is the responder; the master modport is its environment.
// ---------------------------------------------------------------------------
interface si5340_i2c_responder_if;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe_o;
  logic        wr_valid_o;
  logic [23:0] wr_word_o;
  logic [15:0] rd_addr_o;
  logic [7:0]  rd_data_i;
  logic        busy_o;
  logic        nack_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output sda_oe_o, wr_valid_o, wr_word_o, rd_addr_o, busy_o, nack_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i,
    input  sda_oe_o, wr_valid_o, wr_word_o, rd_addr_o, busy_o, nack_o
  );
endinterface

// File: rtl/si5340_i2c_responder.sv
// ---------------------------------------------------------------------------
// si5340_i2c_responder
// I2C target answering the Si5340 config loader. Register writes addressed to
// SLAVE_ADDR are reported as {page, reg, data} records; writing PAGE_REG moves
// the internal page. Reads are served byte by byte from the external read
// port, auto-incrementing reg after every master ACK.
// Ports:
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : si5340_i2c_responder_if.slave (pins, write record, read port,
//           busy/nack flags)
// ---------------------------------------------------------------------------
module si5340_i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'b111_0100,
  parameter logic [7:0] PAGE_REG   = 8'h01,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  si5340_i2c_responder_if.slave        bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_TX        = 4'd7,
    ST_TX_ACK    = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  logic [1:0]            scl_sync_r, sda_sync_r;
  logic                  scl_hist_r, sda_hist_r;
  logic                  scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t                state_r, state_s;
  logic [2:0]            bit_cnt_r, bit_cnt_s;
  logic                  phase_r, phase_s;
  logic                  rw_r, rw_s;
  logic [DATA_WIDTH-2:0] rx_sr_r, rx_sr_s;
  logic [DATA_WIDTH-1:0] rx_byte_s;
  logic [DATA_WIDTH-1:0] tx_sr_r, tx_sr_s;
  logic [7:0]            page_r, page_s, reg_r, reg_s;
  logic                  sda_oe_r, sda_oe_s;
  logic                  wr_valid_r, wr_valid_s;
  logic [23:0]           wr_word_r, wr_word_s;
  logic                  busy_r, busy_s;
  logic                  nack_r, nack_s;

  // Two-FF synchronizers plus one history stage for SCL and SDA.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], bus.scl_i};
      sda_sync_r <= {sda_sync_r[0], bus.sda_i};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_hist_r;
  assign scl_fall_s = ~scl_s & scl_hist_r;
  // START/STOP need SCL high on both sides of the SDA transition.
  assign start_s    = scl_s & scl_hist_r & sda_hist_r & ~sda_s;
  assign stop_s     = scl_s & scl_hist_r & ~sda_hist_r & sda_s;
  // The 8th bit is used straight from the line so the byte is complete on its rising edge.
  assign rx_byte_s  = {rx_sr_r, sda_s};

  // Next-state and next-output logic of the bus protocol engine.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    phase_s    = phase_r;
    rw_s       = rw_r;
    rx_sr_s    = rx_sr_r;
    tx_sr_s    = tx_sr_r;
    page_s     = page_r;
    reg_s      = reg_r;
    sda_oe_s   = sda_oe_r;
    wr_valid_s = 1'b0;
    wr_word_s  = wr_word_r;
    busy_s     = busy_r;
    nack_s     = 1'b0;

    if (start_s) begin
      state_s   = ST_ADDR;
      bit_cnt_s = 3'd0;
      phase_s   = 1'b0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b1;
    end else if (stop_s) begin
      state_s   = ST_IDLE;
      bit_cnt_s = 3'd0;
      phase_s   = 1'b0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise_s) begin
            rx_sr_s   = {rx_sr_r[DATA_WIDTH-3:0], sda_s};
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              phase_s = 1'b0;
              case (state_r)
                ST_ADDR: begin
                  if (rx_byte_s[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                    rw_s    = rx_byte_s[0];
                    state_s = ST_ADDR_ACK;
                  end else begin
                    nack_s  = 1'b1;
                    state_s = ST_IGNORE;
                  end
                end
                ST_REG: begin
                  reg_s   = rx_byte_s;
                  state_s = ST_REG_ACK;
                end
                ST_WDATA: begin
                  wr_valid_s = 1'b1;
                  wr_word_s  = {page_r, reg_r, rx_byte_s};
                  // Record carries the old page; the new page applies to the next record.
                  if (reg_r == PAGE_REG) begin
                    page_s = rx_byte_s;
                  end else begin
                    page_s = page_r;
                  end
                  reg_s   = reg_r + 8'd1;
                  state_s = ST_WDATA_ACK;
                end
                default: state_s = ST_IDLE;
              endcase
            end else begin
              state_s = state_r;
            end
          end else begin
            state_s = state_r;
          end
        end

        // phase 0: first SCL fall pulls SDA low; phase 1: the fall ending the ACK clock.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_s = 1'b1;
              phase_s  = 1'b1;
            end else begin
              phase_s   = 1'b0;
              bit_cnt_s = 3'd0;
              if ((state_r == ST_ADDR_ACK) && rw_r) begin
                sda_oe_s = ~bus.rd_data_i[DATA_WIDTH-1];
                tx_sr_s  = {bus.rd_data_i[DATA_WIDTH-2:0], 1'b0};
                state_s  = ST_TX;
              end else begin
                sda_oe_s = 1'b0;
                state_s  = (state_r == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              end
            end
          end else begin
            state_s = state_r;
          end
        end

        // MSB is already on the line at entry; each fall presents the next bit.
        ST_TX: begin
          if (scl_rise_s) begin
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              phase_s = 1'b0;
              state_s = ST_TX_ACK;
            end else begin
              state_s = state_r;
            end
          end else if (scl_fall_s) begin
            sda_oe_s = ~tx_sr_r[DATA_WIDTH-1];
            tx_sr_s  = {tx_sr_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            state_s = state_r;
          end
        end

        // phase 0: release SDA for the master's ACK; phase 1: ACK seen, reload on the fall.
        ST_TX_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_s = 1'b0;
              phase_s  = 1'b1;
            end else begin
              phase_s   = 1'b0;
              bit_cnt_s = 3'd0;
              sda_oe_s  = ~bus.rd_data_i[DATA_WIDTH-1];
              tx_sr_s   = {bus.rd_data_i[DATA_WIDTH-2:0], 1'b0};
              state_s   = ST_TX;
            end
          end else if (scl_rise_s && phase_r) begin
            if (sda_s) begin
              state_s = ST_IGNORE;
            end else begin
              reg_s = reg_r + 8'd1;
            end
          end else begin
            state_s = state_r;
          end
        end

        ST_IDLE, ST_IGNORE: begin
          state_s = state_r;
        end

        default: begin
          state_s  = ST_IDLE;
          sda_oe_s = 1'b0;
        end
      endcase
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      phase_r    <= 1'b0;
      rw_r       <= 1'b0;
      rx_sr_r    <= '0;
      tx_sr_r    <= '0;
      page_r     <= 8'd0;
      reg_r      <= 8'd0;
      sda_oe_r   <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_word_r  <= 24'd0;
      busy_r     <= 1'b0;
      nack_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      phase_r    <= phase_s;
      rw_r       <= rw_s;
      rx_sr_r    <= rx_sr_s;
      tx_sr_r    <= tx_sr_s;
      page_r     <= page_s;
      reg_r      <= reg_s;
      sda_oe_r   <= sda_oe_s;
      wr_valid_r <= wr_valid_s;
      wr_word_r  <= wr_word_s;
      busy_r     <= busy_s;
      nack_r     <= nack_s;
    end
  end

  assign bus.sda_oe_o   = sda_oe_r;
  assign bus.wr_valid_o = wr_valid_r;
  assign bus.wr_word_o  = wr_word_r;
  assign bus.rd_addr_o  = {page_r, reg_r};
  assign bus.busy_o     = busy_r;
  assign bus.nack_o     = nack_r;

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// ---------------------------------------------------------------------------
// tb_si5340_i2c_responder
// Bit-banged I2C master driving the responder through directed transactions.
// A transaction-level model (page/reg bookkeeping, expected record queue,
// expected NACK count) predicts ACKs, read bytes, write records, busy and
// rd_addr; a compare process checks the DUT every cycle where the model's
// value is settled. Literal expectations pin the model on key results.
// ---------------------------------------------------------------------------
module tb_si5340_i2c_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  si5340_i2c_responder_if bus();

  // Open-drain SDA: the line is low if either side pulls it.
  assign bus.scl_i     = m_scl;
  assign bus.sda_i     = m_sda & ~bus.sda_oe_o;
  assign bus.rd_data_i = bus.rd_addr_o[7:0] ^ 8'hFF;

  si5340_i2c_responder #(
    .SLAVE_ADDR(7'b111_0100),
    .PAGE_REG  (8'h01),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  m_page = 8'h00;
  logic [7:0]  m_reg  = 8'h00;
  bit          m_busy = 1'b0;
  bit          m_match = 1'b0;
  bit          m_rw = 1'b0;
  int          m_idx = 0;
  logic [23:0] exp_wr[$];
  int          exp_nack_total = 0;

  // check enables for the compare process
  bit busy_known   = 1'b0;
  bit rd_known     = 1'b0;
  bit must_release = 1'b0;

  // observations by the compare process
  logic [23:0] seen_words[$];
  int          nack_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // compare process
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wr_valid_o) begin
          seen_words.push_back(bus.wr_word_o);
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_strobe: unexpected record %h, none expected", bus.wr_word_o);
          end else begin
            chk("wr_word", bus.wr_word_o, exp_wr.pop_front());
          end
        end
        if (bus.nack_o) begin
          nack_seen++;
          chk("nack_unexpected", nack_seen, (nack_seen <= exp_nack_total) ? nack_seen : exp_nack_total);
        end
        if (must_release) chk("sda_released", bus.sda_oe_o, 1'b0);
        if (busy_known)   chk("busy", bus.busy_o, m_busy);
        if (rd_known)     chk("rd_addr", bus.rd_addr_o, {m_page, m_reg});
      end
    end
  end

  // model: master-written byte; returns whether the responder must ACK it
  task automatic m_byte(input logic [7:0] b, output bit ack);
    if (m_idx == 0) begin
      m_match = (b[7:1] == 7'b111_0100);
      m_rw    = b[0];
      if (!m_match) exp_nack_total++;
      ack = m_match;
    end else if (!m_match || m_rw) begin
      ack = 1'b0;
    end else if (m_idx == 1) begin
      m_reg = b;
      ack   = 1'b1;
    end else begin
      exp_wr.push_back({m_page, m_reg, b});
      if (m_reg == 8'h01) m_page = b;
      m_reg = m_reg + 8'd1;
      ack   = 1'b1;
    end
    m_idx++;
  endtask

  task automatic i2c_start();
    busy_known   = 1'b0;
    must_release = 1'b0;
    if (m_scl == 1'b0) begin
      tick(5);  m_sda = 1'b1;
      tick(10); m_scl = 1'b1;
      tick(10);
    end
    m_sda = 1'b0;
    tick(10); m_scl = 1'b0;
    m_busy  = 1'b1;
    m_idx   = 0;
    m_match = 1'b0;
    busy_known = 1'b1;
  endtask

  task automatic i2c_stop();
    busy_known = 1'b0;
    tick(5);  m_sda = 1'b0;
    tick(10); m_scl = 1'b1;
    tick(10); m_sda = 1'b1;
    tick(10);
    m_busy  = 1'b0;
    m_match = 1'b0;
    busy_known   = 1'b1;
    must_release = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input string nm);
    bit exp_ack;
    logic line;
    rd_known = 1'b0;
    m_byte(b, exp_ack);
    for (int i = 7; i >= 0; i--) begin
      tick(5);  m_sda = b[i];
      tick(10); m_scl = 1'b1;
      tick(10); m_scl = 1'b0;
    end
    tick(5);  m_sda = 1'b1;
    tick(10); m_scl = 1'b1;
    tick(5);  line = bus.sda_i;
    chk({nm, "_ack"}, line, !exp_ack);
    tick(5);  m_scl = 1'b0;
    if (!m_match) must_release = 1'b1;
    rd_known = 1'b1;
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] got);
    logic [7:0] exp;
    rd_known = 1'b0;
    exp = m_reg ^ 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      tick(5);  m_sda = 1'b1;
      tick(10); m_scl = 1'b1;
      tick(5);  got[i] = bus.sda_i;
      tick(5);  m_scl = 1'b0;
    end
    tick(5);  m_sda = master_ack ? 1'b0 : 1'b1;
    tick(10); m_scl = 1'b1;
    tick(10); m_scl = 1'b0;
    chk("rd_byte", got, exp);
    if (master_ack) m_reg = m_reg + 8'd1;
    else must_release = 1'b1;
    rd_known = 1'b1;
  endtask

  task automatic end_of_test(input string nm);
    chk({nm, "_wr_pending"}, exp_wr.size(), 0);
    chk({nm, "_nack_count"}, nack_seen, exp_nack_total);
  endtask

  initial begin
    int base;
    logic [7:0] got;

    // reset state
    tick(5);
    chk("rst_sda_oe",   bus.sda_oe_o,   1'b0);
    chk("rst_wr_valid", bus.wr_valid_o, 1'b0);
    chk("rst_wr_word",  bus.wr_word_o,  24'h000000);
    chk("rst_rd_addr",  bus.rd_addr_o,  16'h0000);
    chk("rst_busy",     bus.busy_o,     1'b0);
    chk("rst_nack",     bus.nack_o,     1'b0);
    rst = 1'b0;
    tick(20);
    busy_known = 1'b1; rd_known = 1'b1; must_release = 1'b1;

    // 1: page write
    base = seen_words.size();
    i2c_start();
    write_byte(8'hE8, "t1_addr");
    write_byte(8'h01, "t1_reg");
    write_byte(8'h0B, "t1_data");
    i2c_stop();
    chk("t1_strobes", seen_words.size() - base, 1);
    if (seen_words.size() > base) chk("t1_word", seen_words[base], 24'h00010B);
    chk("t1_rd_addr", bus.rd_addr_o, 16'h0B02);
    end_of_test("t1");

    // 2: auto-increment write
    base = seen_words.size();
    i2c_start();
    write_byte(8'hE8, "t2_addr");
    write_byte(8'h45, "t2_reg");
    write_byte(8'hAA, "t2_d0");
    write_byte(8'h55, "t2_d1");
    i2c_stop();
    chk("t2_strobes", seen_words.size() - base, 2);
    if (seen_words.size() > base + 1) begin
      chk("t2_word0", seen_words[base],     24'h0B45AA);
      chk("t2_word1", seen_words[base + 1], 24'h0B4655);
    end
    end_of_test("t2");

    // 3: wrong address
    base = seen_words.size();
    i2c_start();
    write_byte(8'hEA, "t3_addr");
    write_byte(8'h12, "t3_d0");
    i2c_stop();
    chk("t3_strobes", seen_words.size() - base, 0);
    chk("t3_nacks", nack_seen, 1);
    chk("t3_busy_after_stop", bus.busy_o, 1'b0);
    end_of_test("t3");

    // 4: set address, repeated START, read two bytes
    i2c_start();
    write_byte(8'hE8, "t4_addr");
    write_byte(8'h10, "t4_reg");
    i2c_start();
    write_byte(8'hE9, "t4_raddr");
    chk("t4_rd_addr0", bus.rd_addr_o, 16'h0B10);
    read_byte(1'b1, got);
    chk("t4_byte0", got, 8'hEF);
    chk("t4_rd_addr1", bus.rd_addr_o, 16'h0B11);
    read_byte(1'b0, got);
    chk("t4_byte1", got, 8'hEE);
    chk("t4_released", bus.sda_oe_o, 1'b0);
    i2c_stop();
    end_of_test("t4");

    // 5: reg wrap FF -> 00 keeps the page
    base = seen_words.size();
    i2c_start();
    write_byte(8'hE8, "t5_addr");
    write_byte(8'hFF, "t5_reg");
    write_byte(8'h12, "t5_d0");
    write_byte(8'h34, "t5_d1");
    i2c_stop();
    chk("t5_strobes", seen_words.size() - base, 2);
    if (seen_words.size() > base + 1) begin
      chk("t5_word0", seen_words[base],     24'h0BFF12);
      chk("t5_word1", seen_words[base + 1], 24'h0B0034);
    end
    chk("t5_rd_addr", bus.rd_addr_o, 16'h0B01);
    end_of_test("t5");

    // 6: reset while transmitting 0x00, then a normal write
    i2c_start();
    write_byte(8'hE8, "t6_addr");
    write_byte(8'hFF, "t6_reg");
    i2c_start();
    write_byte(8'hE9, "t6_raddr");
    rd_known = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(5);  m_sda = 1'b1;
      tick(10); m_scl = 1'b1;
      tick(5);  chk("t6_tx_bit", bus.sda_i, 1'b0);
      tick(5);  m_scl = 1'b0;
    end
    tick(5);
    chk("t6_driving", bus.sda_oe_o, 1'b1);
    busy_known = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_sda_after_rst", bus.sda_oe_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_page = 8'h00; m_reg = 8'h00; m_busy = 1'b0; m_match = 1'b0;
    chk("t6_busy_after_rst", bus.busy_o, 1'b0);
    chk("t6_rd_addr_after_rst", bus.rd_addr_o, 16'h0000);
    rd_known = 1'b1; busy_known = 1'b1; must_release = 1'b1;
    i2c_stop();
    base = seen_words.size();
    i2c_start();
    write_byte(8'hE8, "t6w_addr");
    write_byte(8'h01, "t6w_reg");
    write_byte(8'h22, "t6w_data");
    i2c_stop();
    chk("t6_strobes", seen_words.size() - base, 1);
    if (seen_words.size() > base) chk("t6_word", seen_words[base], 24'h000122);
    chk("t6_rd_addr", bus.rd_addr_o, 16'h2202);
    end_of_test("t6");

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
